// File: rtl/ps2_scan_ctrl.sv
// PS/2 set-2 scan sequencer: pops bytes from the receiver FIFO, strips E0/F0 prefixes, emits key events.
// Optional build macro REPEAT_FILTER_EN suppresses key_valid for typematic repeats.
module ps2_scan_ctrl #(
    parameter int CNT_W   = 8,
    parameter int POP_GAP = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kbd_ready,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic             key_repeat,
    output logic             held_valid,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] key_count,
    output logic             proto_err
);

    // state   | meaning
    // P_IDLE  | waiting for kbd_ready; pops the head byte combinationally
    // P_GAP   | POP_GAP idle cycles so the FIFO head can advance
    // S_NORM  | no prefix pending
    // S_EXT   | E0 seen
    // S_BRK   | F0 seen
    // S_EXTBRK| E0 F0 seen

`ifdef REPEAT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    localparam int GAP_W = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;

    typedef enum logic {P_IDLE, P_GAP} pop_state_t;
    typedef enum logic [1:0] {S_NORM, S_EXT, S_BRK, S_EXTBRK} ps_state_t;

    pop_state_t       pop_state, pop_next;
    logic [GAP_W-1:0] gap_cnt, gap_next;
    logic             pop_fire;

    ps_state_t        ps_state, ps_cur, ps_next;
    logic             ovf_q, ovf_rise;
    logic             emit, ev_ext, ev_brk, err_set, is_drop, is_rep, pulse;
    logic [8:0]       ev_key;

    always_comb begin
        pop_next = pop_state;
        gap_next = gap_cnt;
        pop_fire = 1'b0;
        case (pop_state)
            P_IDLE: begin
                if (kbd_ready && rst_n) begin
                    pop_fire = 1'b1;
                    pop_next = P_GAP;
                    gap_next = GAP_W'(POP_GAP - 1);
                end
            end
            P_GAP: begin
                if (gap_cnt == '0) pop_next = P_IDLE;
                else               gap_next = gap_cnt - GAP_W'(1);
            end
            default: pop_next = P_IDLE;
        endcase
    end

    assign kbd_nextdata_n = ~pop_fire;

    assign ovf_rise = kbd_overflow & ~ovf_q;

    always_comb begin
        is_drop = (kbd_data == 8'hAA) || (kbd_data == 8'hFA) || (kbd_data == 8'hEE) ||
                  (kbd_data == 8'hFE) || (kbd_data == 8'h00) || (kbd_data == 8'hFF);
    end

    // An overflow edge resyncs to NORM first, so a byte popped in that cycle starts a fresh sequence.
    always_comb begin
        ps_cur  = ovf_rise ? S_NORM : ps_state;
        ps_next = ps_cur;
        emit    = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        err_set = ovf_rise;
        if (pop_fire) begin
            case (ps_cur)
                S_NORM: begin
                    if (kbd_data == 8'hE0)      ps_next = S_EXT;
                    else if (kbd_data == 8'hF0) ps_next = S_BRK;
                    else if (!is_drop)          emit = 1'b1;
                end
                S_EXT: begin
                    if (kbd_data == 8'hF0)      ps_next = S_EXTBRK;
                    else if (kbd_data != 8'hE0) begin
                        emit    = 1'b1;
                        ev_ext  = 1'b1;
                        ps_next = S_NORM;
                    end
                end
                S_BRK: begin
                    ps_next = S_NORM;
                    if (kbd_data == 8'hF0 || kbd_data == 8'hE0) err_set = 1'b1;
                    else begin
                        emit   = 1'b1;
                        ev_brk = 1'b1;
                    end
                end
                S_EXTBRK: begin
                    ps_next = S_NORM;
                    if (kbd_data == 8'hF0 || kbd_data == 8'hE0) err_set = 1'b1;
                    else begin
                        emit   = 1'b1;
                        ev_ext = 1'b1;
                        ev_brk = 1'b1;
                    end
                end
                default: ps_next = S_NORM;
            endcase
        end
    end

    assign ev_key = {ev_ext, kbd_data};
    assign is_rep = ~ev_brk & held_valid & (held_code == ev_key);
    assign pulse  = emit & ~(FILTER & is_rep);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pop_state  <= P_IDLE;
            gap_cnt    <= '0;
            ps_state   <= S_NORM;
            ovf_q      <= 1'b0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            key_repeat <= 1'b0;
            held_valid <= 1'b0;
            held_code  <= '0;
            key_count  <= '0;
            proto_err  <= 1'b0;
        end else begin
            pop_state <= pop_next;
            gap_cnt   <= gap_next;
            ps_state  <= ps_next;
            ovf_q     <= kbd_overflow;
            key_valid <= pulse;
            if (err_set) proto_err <= 1'b1;
            if (pulse) begin
                key_code   <= kbd_data;
                key_ext    <= ev_ext;
                key_break  <= ev_brk;
                key_repeat <= is_rep;
            end
            if (emit && !ev_brk && !is_rep) begin
                key_count  <= key_count + CNT_W'(1);
                held_code  <= ev_key;
                held_valid <= 1'b1;
            end
            if (emit && ev_brk && (held_code == ev_key)) held_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Bench for ps2_scan_ctrl: upstream FIFO model, per-cycle behavioural reference, directed sequences.
module tb_ps2_scan_ctrl;

    localparam int POP_GAP = 2;
    localparam int CNT_W   = 8;
`ifdef REPEAT_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             kbd_ready;
    logic [7:0]       kbd_data;
    logic             kbd_overflow;
    logic             kbd_nextdata_n;
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_break;
    logic             key_repeat;
    logic             held_valid;
    logic [8:0]       held_code;
    logic [CNT_W-1:0] key_count;
    logic             proto_err;

    ps2_scan_ctrl #(.CNT_W(CNT_W), .POP_GAP(POP_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .kbd_ready(kbd_ready), .kbd_data(kbd_data),
        .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n), .key_valid(key_valid),
        .key_code(key_code), .key_ext(key_ext), .key_break(key_break), .key_repeat(key_repeat),
        .held_valid(held_valid), .held_code(held_code), .key_count(key_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_on  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference: prefix memory plus held-key bookkeeping, updated once per clock edge
    byte unsigned fifo[$];
    int   since;
    bit   pf_ext, pf_brk, prev_ovf, m_popped;
    bit   m_valid, m_ext, m_brk, m_rep, m_hv, m_err;
    logic [7:0] m_code;
    logic [8:0] m_hc;
    logic [CNT_W-1:0] m_cnt;
    int   m_pulses;

    task automatic m_reset();
        since = POP_GAP + 1;
        pf_ext = 0; pf_brk = 0; prev_ovf = 0;
        m_valid = 0; m_ext = 0; m_brk = 0; m_rep = 0; m_hv = 0; m_err = 0;
        m_code = '0; m_hc = '0; m_cnt = '0;
    endtask

    task automatic m_emit(bit ext, bit brk, logic [7:0] b);
        logic [8:0] key;
        bit rep;
        key = {ext, b};
        rep = 0;
        if (!brk) begin
            rep = m_hv && (m_hc == key);
            if (!rep) begin
                m_cnt = m_cnt + 1'b1;
                m_hc  = key;
                m_hv  = 1;
            end
        end else if (m_hc == key) begin
            m_hv = 0;
        end
        if (!(FILTER && rep)) begin
            m_valid = 1; m_code = b; m_ext = ext; m_brk = brk; m_rep = rep;
            m_pulses++;
        end
        pf_ext = 0; pf_brk = 0;
    endtask

    task automatic m_parse(logic [7:0] b);
        bit junk;
        junk = (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
        if (b == 8'hE0 || b == 8'hF0) begin
            if (pf_brk) begin
                m_err = 1; pf_ext = 0; pf_brk = 0;
            end else if (b == 8'hE0) pf_ext = 1;
            else pf_brk = 1;
        end else if (!pf_ext && !pf_brk && junk) begin
        end else begin
            m_emit(pf_ext, pf_brk, b);
        end
    endtask

    task automatic model_update();
        bit pop;
        m_valid = 0;
        if (!rst_n) begin
            m_reset();
            m_popped = 0;
            return;
        end
        pop = kbd_ready && (since > POP_GAP);
        m_popped = pop;
        if (kbd_overflow && !prev_ovf) begin
            m_err = 1; pf_ext = 0; pf_brk = 0;
        end
        prev_ovf = kbd_overflow;
        since = pop ? 1 : ((since < 1000) ? since + 1 : since);
        if (pop) m_parse(kbd_data);
    endtask

    task automatic drive();
        if (m_popped && fifo.size() != 0) void'(fifo.pop_front());
        kbd_ready = (fifo.size() != 0);
        kbd_data  = kbd_ready ? fifo[0] : 8'h00;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_update();
        drive();
    endtask

    task automatic push(byte unsigned b);
        fifo.push_back(b);
        kbd_ready = 1'b1;
        kbd_data  = fifo[0];
    endtask

    task automatic run_drain();
        int budget;
        budget = 0;
        while (fifo.size() != 0 && budget < 200) begin
            cycle();
            budget++;
        end
        if (fifo.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d bytes left expected 0", fifo.size());
        end
        repeat (POP_GAP + 3) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    int pop_cyc[$];
    int val_cyc[$];
    int dut_pulses = 0;

    // per-cycle comparison against the reference
    always @(negedge clk) begin
        if (chk_on) begin
            chk("nextdata_n", kbd_nextdata_n, !(rst_n && kbd_ready && (since > POP_GAP)));
            chk("key_valid", key_valid, m_valid);
            chk("key_code", key_code, m_code);
            chk("key_ext", key_ext, m_ext);
            chk("key_break", key_break, m_brk);
            chk("key_repeat", key_repeat, m_rep);
            chk("held_valid", held_valid, m_hv);
            chk("held_code", held_code, m_hc);
            chk("key_count", key_count, m_cnt);
            chk("proto_err", proto_err, m_err);
            if (kbd_nextdata_n === 1'b0) pop_cyc.push_back(cyc);
            if (key_valid === 1'b1) begin
                val_cyc.push_back(cyc);
                dut_pulses++;
            end
        end
    end

    int p0, mp0;

    initial begin
        rst_n = 1'b0; kbd_ready = 1'b0; kbd_data = 8'h00; kbd_overflow = 1'b0;
        m_pulses = 0; m_popped = 0;
        m_reset();
        cycle();
        chk_on = 1'b1;
        push(8'h1C);
        cycle();
        chk("rst_nextdata_n", kbd_nextdata_n, 1);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_count", key_count, 0);
        chk("rst_held_valid", held_valid, 0);
        chk("rst_proto_err", proto_err, 0);

        // single press, pop-to-valid latency
        pop_cyc.delete(); val_cyc.delete();
        rst_n = 1'b1;
        run_drain();
        chk("t1_pops", pop_cyc.size(), 1);
        chk("t1_pulses", val_cyc.size(), 1);
        if (pop_cyc.size() == 1 && val_cyc.size() == 1)
            chk("t1_latency", val_cyc[0] - pop_cyc[0], 1);
        chk("t1_code", key_code, 8'h1C);
        chk("t1_count", key_count, 1);
        chk("t1_held_code", held_code, 9'h01C);
        chk("t1_held_valid", held_valid, 1);

        // typematic repeats then release; burst spacing
        do_reset();
        pop_cyc.delete();
        p0 = dut_pulses; mp0 = m_pulses;
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        run_drain();
        chk("t2_pulses", dut_pulses - p0, FILTER ? 2 : 4);
        chk("t2_model_pulses", m_pulses - mp0, FILTER ? 2 : 4);
        chk("t2_count", key_count, 1);
        chk("t2_held_valid", held_valid, 0);
        chk("t2_break", key_break, 1);
        chk("t2_npops", pop_cyc.size(), 5);
        for (int i = 1; i < pop_cyc.size(); i++)
            chk("t2_pop_spacing", pop_cyc[i] - pop_cyc[i-1], POP_GAP + 1);

        // extended press and release
        push(8'hE0); push(8'h75);
        run_drain();
        chk("t3_held_code", held_code, 9'h175);
        chk("t3_held_valid", held_valid, 1);
        chk("t3_ext", key_ext, 1);
        chk("t3_count", key_count, 2);
        push(8'hE0); push(8'hF0); push(8'h75);
        run_drain();
        chk("t3_rel_held_valid", held_valid, 0);
        chk("t3_rel_code", key_code, 8'h75);
        chk("t3_rel_ext", key_ext, 1);
        chk("t3_rel_break", key_break, 1);
        chk("t3_err", proto_err, 0);

        // dropped byte and illegal double break
        p0 = dut_pulses;
        push(8'hAA); push(8'hF0); push(8'hF0); push(8'h1C);
        run_drain();
        chk("t4_err", proto_err, 1);
        chk("t4_pulses", dut_pulses - p0, 1);
        chk("t4_code", key_code, 8'h1C);
        chk("t4_ext", key_ext, 0);
        chk("t4_break", key_break, 0);
        chk("t4_count", key_count, 3);

        // reset mid-sequence after E0
        push(8'hE0);
        run_drain();
        rst_n = 1'b0;
        push(8'h1C);
        cycle();
        chk("t5_rst_nextdata_n", kbd_nextdata_n, 1);
        cycle();
        chk("t5_err", proto_err, 0);
        chk("t5_count", key_count, 0);
        chk("t5_code", key_code, 0);
        chk("t5_held", held_code, 0);
        rst_n = 1'b1;
        run_drain();
        chk("t5_ext", key_ext, 0);
        chk("t5_code_after", key_code, 8'h1C);
        chk("t5_count_after", key_count, 1);

        // overflow resync after a dangling E0
        push(8'hE0);
        run_drain();
        kbd_overflow = 1'b1;
        cycle();
        cycle();
        push(8'h2B);
        run_drain();
        chk("t6_err", proto_err, 1);
        chk("t6_ext", key_ext, 0);
        chk("t6_code", key_code, 8'h2B);
        chk("t6_count", key_count, 2);
        kbd_overflow = 1'b0;
        cycle();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
